// File: rtl/iq_pkg.sv
// iq_pkg: shared entry type and padding constants for the instruction queue.
package iq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam iq_entry_t PAD_ENTRY = '{pc: 32'h0, instr: NOP_INSTR};

endpackage

// File: rtl/iq_ring_queue_if.sv
// iq_ring_queue_if: enqueue/dequeue handshake bundle between fetch, the queue and decode.
interface iq_ring_queue_if #(
    parameter int ISSUE_WIDTH = 4,
    parameter int FETCH_WIDTH = 10,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(FETCH_WIDTH + 1);
    localparam int NW = $clog2(DEPTH + 1);

    logic                      i_flush;
    logic                      i_enqValid;
    logic [CW-1:0]             i_enqCount;
    logic [64*FETCH_WIDTH-1:0] i_enqData;
    logic                      o_enqReady;
    logic [NW-1:0]             o_room;
    logic                      o_deqValid;
    logic                      i_deqReady;
    logic [64*ISSUE_WIDTH-1:0] o_deqData;
    logic [ISSUE_WIDTH-1:0]    o_deqMask;

    modport master (
        output i_flush, i_enqValid, i_enqCount, i_enqData, i_deqReady,
        input  o_enqReady, o_room, o_deqValid, o_deqData, o_deqMask
    );

    modport slave (
        input  i_flush, i_enqValid, i_enqCount, i_enqData, i_deqReady,
        output o_enqReady, o_room, o_deqValid, o_deqData, o_deqMask
    );

endinterface

// File: rtl/iq_window_mux.sv
// iq_window_mux: rotates the ring so the oldest entries land in slot 0, padding empty slots.
module iq_window_mux import iq_pkg::*; #(
    parameter int ISSUE_WIDTH = 4,
    parameter int DEPTH = 16,
    parameter iq_entry_t PAD = PAD_ENTRY,
    localparam int PW = $clog2(DEPTH),
    localparam int NW = $clog2(DEPTH + 1)
) (
    input  iq_entry_t                 mem [DEPTH],
    input  logic [PW-1:0]             head,
    input  logic [NW-1:0]             num,
    output logic [64*ISSUE_WIDTH-1:0] data,
    output logic [ISSUE_WIDTH-1:0]    mask
);

    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
        logic [PW-1:0] idx;
        assign idx = head + PW'(k);
        assign mask[k] = NW'(k) < num;
        assign data[64*k +: 64] = mask[k] ? mem[idx] : PAD;
    end

endmodule

// File: rtl/iq_ring_queue.sv
// iq_ring_queue: circular instruction queue between fetch/align and decode.
// Define IQ_PERF_CNT_EN to add stall/empty/issued performance counters.
module iq_ring_queue #(
    parameter int ISSUE_WIDTH = 4,
    parameter int FETCH_WIDTH = 10,
    parameter int DEPTH = 16,
    parameter logic [31:0] NOP_INSTR = iq_pkg::NOP_INSTR
) (
    input  logic clk,
    input  logic rst,
    iq_ring_queue_if.slave q
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0] o_stallCnt,
    output logic [31:0] o_emptyCnt,
    output logic [31:0] o_issuedCnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);

    iq_pkg::iq_entry_t mem [DEPTH];
    logic [PW-1:0] head, tail;
    logic [NW-1:0] num, room, pop_n;
    logic enq_ready, deq_valid, enq, deq;

    // Room comes from pre-edge occupancy only, so a same-cycle pop never frees space.
    assign room      = NW'(DEPTH) - num;
    assign enq_ready = NW'(q.i_enqCount) <= room;
    assign deq_valid = num != '0;
    assign pop_n     = num > NW'(ISSUE_WIDTH) ? NW'(ISSUE_WIDTH) : num;
    assign enq       = q.i_enqValid && enq_ready && q.i_enqCount != '0;
    assign deq       = deq_valid && q.i_deqReady;

    assign q.o_enqReady = enq_ready;
    assign q.o_room     = room;
    assign q.o_deqValid = deq_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            num  <= '0;
        end else if (q.i_flush) begin
            head <= '0;
            tail <= '0;
            num  <= '0;
        end else begin
            if (enq) tail <= tail + PW'(q.i_enqCount);
            if (deq) head <= head + PW'(pop_n);
            num <= num + (enq ? NW'(q.i_enqCount) : '0) - (deq ? pop_n : '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_WIDTH; k++)
            if (enq && k < int'(q.i_enqCount)) mem[tail + PW'(k)] <= q.i_enqData[64*k +: 64];
    end

    iq_window_mux #(
        .ISSUE_WIDTH(ISSUE_WIDTH),
        .DEPTH(DEPTH),
        .PAD(iq_pkg::iq_entry_t'({32'h0, NOP_INSTR}))
    ) u_mux (
        .mem(mem),
        .head(head),
        .num(num),
        .data(q.o_deqData),
        .mask(q.o_deqMask)
    );

`ifdef IQ_PERF_CNT_EN
    // Counters survive flush; a flushed cycle's group was never issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_stallCnt  <= '0;
            o_emptyCnt  <= '0;
            o_issuedCnt <= '0;
        end else begin
            o_stallCnt  <= o_stallCnt + 32'(q.i_enqValid && !enq_ready);
            o_emptyCnt  <= o_emptyCnt + 32'(!deq_valid);
            o_issuedCnt <= o_issuedCnt + (deq && !q.i_flush ? 32'(pop_n) : 32'h0);
        end
    end
`endif

endmodule
